sub_div_ctrl: RTL and testbench

- Sequencer that drives the team's 8-bit subtract-accumulator (SPE/CE/D in, Q out) to compute unsigned quotient and remainder by repeated subtraction.
- Sits beside the accumulator in the HEX2BIN datapath, between a requester and the accumulator.
- The requester uses a start/busy/done handshake; this block owns all accumulator control lines.

---
 rtl/sub_div_ctrl_pkg.sv | 18 +
 rtl/sub_div_ctrl.sv | 140 ++++++++++++++
 tb/tb_sub_div_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sub_div_ctrl_pkg.sv
// Shared types and constants for the repeated-subtraction divider sequencer.
// Optional abort input is enabled with the SUB_DIV_CTRL_ABORT_EN macro (see sub_div_ctrl).
package sub_div_ctrl_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Divide-by-zero quotient; every bit is set, so it replicates to any width.
  localparam logic [WIDTH_DEF-1:0] QUOT_ALL_ONES = '1;

endpackage

// File: rtl/sub_div_ctrl.sv
// Drives an external subtract-accumulator to divide by repeated subtraction; done q+3 edges after start.
// Define SUB_DIV_CTRL_ABORT_EN to add an abort input that drops CLEAR/LOAD/RUN back to IDLE.
module sub_div_ctrl
  import sub_div_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             CLR,
`ifdef SUB_DIV_CTRL_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_err,
  output logic             acc_spe,
  output logic             acc_ce,
  output logic [WIDTH-1:0] acc_d,
  input  logic [WIDTH-1:0] acc_q
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_err_q, div_err_d;
  logic             abort_hit;
  logic             run_ge;

`ifdef SUB_DIV_CTRL_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign run_ge = (acc_q >= divisor_q);

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q     <= IDLE;
      dividend_q  <= '0;
      divisor_q   <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_err_q   <= div_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_err_d   = div_err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dividend_d = dividend;
          divisor_d  = divisor;
          count_d    = '0;
          if (divisor == '0) begin
            state_d     = DONE;
            div_err_d   = 1'b1;
            quotient_d  = {WIDTH{QUOT_ALL_ONES[0]}};
            remainder_d = dividend;
          end else begin
            state_d = CLEAR;
          end
        end
      end
      CLEAR: state_d = abort_hit ? IDLE : LOAD;
      LOAD:  state_d = abort_hit ? IDLE : RUN;
      RUN: begin
        if (abort_hit) begin
          state_d = IDLE;
        end else if (run_ge) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          quotient_d  = count_q;
          remainder_d = acc_q;
          div_err_d   = 1'b0;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    acc_spe = 1'b0;
    acc_ce  = 1'b0;
    acc_d   = '0;
    if (!abort_hit) begin
      case (state_q)
        CLEAR: begin
          acc_spe = 1'b1;
          acc_ce  = 1'b1;
        end
        // Accumulator computes Q - D, so loading -dividend onto a cleared Q leaves dividend.
        LOAD: begin
          acc_ce = 1'b1;
          acc_d  = -dividend_q;
        end
        RUN: begin
          if (run_ge) begin
            acc_ce = 1'b1;
            acc_d  = divisor_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_err   = div_err_q;

endmodule

// File: tb/tb_sub_div_ctrl.sv
// Bench for sub_div_ctrl paired with a behavioural subtract-accumulator (SPE clears Q, else Q <= Q - D).
// Abort sequence is included only when SUB_DIV_CTRL_ABORT_EN is defined.
module tb_sub_div_ctrl;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       start;
  logic [7:0] dividend, divisor;
  logic       busy, done, div_err, acc_spe, acc_ce;
  logic [7:0] quotient, remainder, acc_d;
  logic [7:0] acc_q = 8'hA5;
`ifdef SUB_DIV_CTRL_ABORT_EN
  logic       abort;
`endif

  int n_total = 0;
  int n_pass  = 0;

  sub_div_ctrl #(.WIDTH(8)) dut (
    .CLK       (CLK),
    .CLR       (CLR),
`ifdef SUB_DIV_CTRL_ABORT_EN
    .abort     (abort),
`endif
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_err   (div_err),
    .acc_spe   (acc_spe),
    .acc_ce    (acc_ce),
    .acc_d     (acc_d),
    .acc_q     (acc_q)
  );

  always #5 CLK = ~CLK;

  // Accumulator model: not reset by CLR, so each job relies on the CLEAR preset.
  always @(posedge CLK) begin
    if (acc_ce) acc_q <= acc_spe ? 8'h00 : (acc_q - acc_d);
  end

  typedef struct {
    logic [7:0] dvd;
    logic [7:0] dvs;
    logic [7:0] exp_q;
    logic [7:0] exp_r;
    logic       exp_e;
    int         exp_lat;  // posedges after the sampling edge until done rises
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic run_job(input vec_t v);
    int  lat = 0, ce_n = 0, spe_n = 0, d_bad = 0, busy_bad = 0;
    bit  seen = 0;
    @(negedge CLK);
    dividend = v.dvd;
    divisor  = v.dvs;
    start    = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge CLK);
      start = 1'b0;
      if (acc_ce) ce_n++;
      if (acc_spe) spe_n++;
      if (!acc_ce && acc_d != 8'h00) d_bad++;
      if (!busy) busy_bad++;
      if (done) begin
        lat  = k;
        seen = 1;
        break;
      end
    end
    check($sformatf("done_seen %0d/%0d", v.dvd, v.dvs), int'(seen), 1);
    check($sformatf("latency %0d/%0d", v.dvd, v.dvs), lat, v.exp_lat);
    check($sformatf("quotient %0d/%0d", v.dvd, v.dvs), int'(quotient), int'(v.exp_q));
    check($sformatf("remainder %0d/%0d", v.dvd, v.dvs), int'(remainder), int'(v.exp_r));
    check($sformatf("div_err %0d/%0d", v.dvd, v.dvs), int'(div_err), int'(v.exp_e));
    // CE covers CLEAR, LOAD and one cycle per successful subtraction.
    check($sformatf("ce_cycles %0d/%0d", v.dvd, v.dvs), ce_n, v.exp_e ? 0 : int'(v.exp_q) + 2);
    check($sformatf("spe_cycles %0d/%0d", v.dvd, v.dvs), spe_n, v.exp_e ? 0 : 1);
    check($sformatf("acc_d_idle_zero %0d/%0d", v.dvd, v.dvs), d_bad, 0);
    check($sformatf("busy_throughout %0d/%0d", v.dvd, v.dvs), busy_bad, 0);
    @(negedge CLK);
    check($sformatf("idle_after_done %0d/%0d", v.dvd, v.dvs), int'({busy, done}), 0);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge CLK);
      if (done) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_done_seen"}, int'(seen), 1);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'd200, 8'd7,  8'd28,  8'd4,    1'b0, 31};
    vecs[1] = '{8'd5,   8'd9,  8'd0,   8'd5,    1'b0, 3};
    vecs[2] = '{8'd255, 8'd1,  8'd255, 8'd0,    1'b0, 258};
    vecs[3] = '{8'h3C,  8'd0,  8'hFF,  8'h3C,   1'b1, 0};  // done in the first cycle after sampling
    vecs[4] = '{8'd7,   8'd7,  8'd1,   8'd0,    1'b0, 4};
    vecs[5] = '{8'd0,   8'd5,  8'd0,   8'd0,    1'b0, 3};
    vecs[6] = '{8'd255, 8'd255, 8'd1,  8'd0,    1'b0, 4};

    CLR      = 1'b1;
    start    = 1'b0;
    dividend = 8'h00;
    divisor  = 8'h00;
`ifdef SUB_DIV_CTRL_ABORT_EN
    abort    = 1'b0;
`endif
    repeat (2) @(negedge CLK);
    check("reset_ctrl", int'({busy, done, div_err, acc_spe, acc_ce}), 0);
    check("reset_acc_d", int'(acc_d), 0);
    check("reset_results", int'({quotient, remainder}), 0);
    CLR = 1'b0;

    foreach (vecs[i]) run_job(vecs[i]);

    // New start mid-RUN must be ignored.
    @(negedge CLK);
    dividend = 8'd200; divisor = 8'd7; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (10) @(negedge CLK);
    dividend = 8'd50; divisor = 8'd5; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_done("restart");
    check("restart_quotient", int'(quotient), 28);
    check("restart_remainder", int'(remainder), 4);

    // Asynchronous CLR mid-RUN clears outputs without waiting for an edge.
    repeat (2) @(negedge CLK);
    dividend = 8'd100; divisor = 8'd3; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (10) @(negedge CLK);
    check("pre_clr_busy", int'(busy), 1);
    CLR = 1'b1;
    #1;
    check("clr_ctrl", int'({busy, done, div_err, acc_spe, acc_ce}), 0);
    check("clr_results", int'({quotient, remainder, acc_d}), 0);
    @(negedge CLK);
    CLR = 1'b0;
    run_job('{8'd100, 8'd10, 8'd10, 8'd0, 1'b0, 13});

`ifdef SUB_DIV_CTRL_ABORT_EN
    @(negedge CLK);
    dividend = 8'd200; divisor = 8'd7; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (10) @(negedge CLK);
    abort = 1'b1;
    #1;
    check("abort_ce_low", int'(acc_ce), 0);
    @(negedge CLK);
    abort = 1'b0;
    check("abort_idle", int'({busy, done}), 0);
    check("abort_results_kept", int'({quotient, remainder}), int'({8'd10, 8'd0}));
    begin
      int done_n = 0;
      repeat (40) begin
        @(negedge CLK);
        if (done) done_n++;
      end
      check("abort_no_done", done_n, 0);
    end
    run_job('{8'd9, 8'd4, 8'd2, 8'd1, 1'b0, 5});
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
